// File: rtl/i2c_byte_write_master_pkg.sv
// Shared constants for the single-byte I2C write master: state encoding,
// R/W bit value and default quarter-period length.
package i2c_byte_write_master_pkg;

    localparam int QUARTER_DEFAULT = 125;
    localparam logic RW_WRITE = 1'b0;

    typedef logic [3:0] state_t;

    // Each byte state is immediately followed by its ACK state in this encoding.
    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_START     = 4'd1;
    localparam state_t ST_DEV_ADDR  = 4'd2;
    localparam state_t ST_ACK1      = 4'd3;
    localparam state_t ST_DATA_ADDR = 4'd4;
    localparam state_t ST_ACK2      = 4'd5;
    localparam state_t ST_WR_DATA   = 4'd6;
    localparam state_t ST_ACK3      = 4'd7;
    localparam state_t ST_STOP      = 4'd8;
    localparam state_t ST_DONE      = 4'd9;

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period timebase: counts QUARTER system clocks per quarter and
// tracks the quarter phase q within a 4-quarter SCL period.
module i2c_quarter_tick #(
    parameter int QUARTER = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    output logic       tick_o,
    output logic [1:0] q_o
);

    localparam int CW = $clog2(QUARTER);
    localparam logic [CW-1:0] LAST = CW'(QUARTER - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    q_q, q_d;

    assign tick_o = !clr_i && (cnt_q == LAST);
    assign q_o    = q_q;

    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_q;
        if (clr_i) begin
            cnt_d = '0;
            q_d   = '0;
        end else if (tick_o) begin
            cnt_d = '0;
            q_d   = q_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            q_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

endmodule

// File: rtl/i2c_byte_write_master.sv
// Single-byte I2C write master: START, dev addr + W, register addr, data, STOP.
//  state     | meaning
//  IDLE      | bus released, waiting for i_i2c_en
//  START     | START condition (SDA falls while SCL high)
//  DEV_ADDR  | shifting {device_addr, W}, MSB first
//  ACK1      | SDA released, sample slave ACK for device address
//  DATA_ADDR | shifting register address
//  ACK2      | sample slave ACK for register address
//  WR_DATA   | shifting write data
//  ACK3      | sample slave ACK for data
//  STOP      | STOP condition (SDA rises while SCL high)
//  DONE      | one-cycle done pulse, then IDLE
module i2c_byte_write_master
    import i2c_byte_write_master_pkg::*;
#(
    parameter int QUARTER = QUARTER_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_i2c_en,
    input  logic [6:0] i_device_addr,
    input  logic [7:0] i_data_addr,
    input  logic [7:0] i_write_data,
    output logic       o_done_flag,
    output logic       o_scl,
    output logic       o_sda_mode,
    inout  wire        io_sda
);

    state_t     state_q, state_d;
    logic [7:0] dev_q, dev_d, daddr_q, daddr_d, wdata_q, wdata_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_q, bit_d;
    logic       nack_q, nack_d;
    logic       scl_q, scl_d, sda_q, sda_d, mode_q, mode_d, done_q, done_d;

    logic       tick;
    logic [1:0] q;
    logic       slot_end;

    i2c_quarter_tick #(.QUARTER(QUARTER)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == ST_IDLE),
        .tick_o (tick),
        .q_o    (q)
    );

    assign slot_end = tick && (q == 2'd3);

    always_comb begin
        state_d = state_q;
        dev_d   = dev_q;
        daddr_d = daddr_q;
        wdata_d = wdata_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        nack_d  = nack_q;
        case (state_q)
            ST_IDLE: begin
                if (i_i2c_en) begin
                    state_d = ST_START;
                    dev_d   = {i_device_addr, RW_WRITE};
                    daddr_d = i_data_addr;
                    wdata_d = i_write_data;
                    nack_d  = 1'b0;
                end
            end
            ST_START: begin
                if (slot_end) begin
                    state_d = ST_DEV_ADDR;
                    shift_d = dev_q;
                    bit_d   = 3'd0;
                end
            end
            ST_DEV_ADDR, ST_DATA_ADDR, ST_WR_DATA: begin
                if (slot_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = state_q + 4'd1;
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            ST_ACK1, ST_ACK2, ST_ACK3: begin
                if (tick && (q == 2'd1)) begin
                    nack_d = io_sda;
                end
                if (slot_end) begin
                    bit_d = 3'd0;
                    if (nack_q || (state_q == ST_ACK3)) begin
                        state_d = ST_STOP;
                    end else if (state_q == ST_ACK1) begin
                        state_d = ST_DATA_ADDR;
                        shift_d = daddr_q;
                    end else begin
                        state_d = ST_WR_DATA;
                        shift_d = wdata_q;
                    end
                end
            end
            ST_STOP: begin
                if (slot_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus levels are decoded from the current state/phase and registered so
    // the pins are glitch-free; every line lags the phase by one clk alike.
    always_comb begin
        scl_d  = 1'b1;
        sda_d  = 1'b1;
        mode_d = 1'b1;
        done_d = 1'b0;
        case (state_q)
            ST_START: begin
                scl_d = (q != 2'd3);
                sda_d = (q == 2'd0);
            end
            ST_DEV_ADDR, ST_DATA_ADDR, ST_WR_DATA: begin
                scl_d = q[0] ^ q[1];
                sda_d = shift_q[7];
            end
            ST_ACK1, ST_ACK2, ST_ACK3: begin
                scl_d  = q[0] ^ q[1];
                mode_d = 1'b0;
            end
            ST_STOP: begin
                scl_d = (q != 2'd0);
                sda_d = q[1];
            end
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dev_q   <= '0;
            daddr_q <= '0;
            wdata_q <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            nack_q  <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            mode_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dev_q   <= dev_d;
            daddr_q <= daddr_d;
            wdata_q <= wdata_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            nack_q  <= nack_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign o_scl       = scl_q;
    assign o_sda_mode  = mode_q;
    assign o_done_flag = done_q;
    assign io_sda      = mode_q ? sda_q : 1'bz;

endmodule

// File: tb/tb_i2c_byte_write_master.sv
// Directed bench for i2c_byte_write_master with an ACKing slave model on io_sda.
module tb_i2c_byte_write_master;

    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_i2c_en;
    logic [6:0] i_device_addr;
    logic [7:0] i_data_addr;
    logic [7:0] i_write_data;
    logic       o_done_flag;
    logic       o_scl;
    logic       o_sda_mode;
    wire        io_sda;
    logic       ack_en;

    int n_checks = 0;
    int n_err    = 0;

    i2c_byte_write_master #(.QUARTER(Q)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_i2c_en      (i_i2c_en),
        .i_device_addr (i_device_addr),
        .i_data_addr   (i_data_addr),
        .i_write_data  (i_write_data),
        .o_done_flag   (o_done_flag),
        .o_scl         (o_scl),
        .o_sda_mode    (o_sda_mode),
        .io_sda        (io_sda)
    );

    pullup (io_sda);
    assign io_sda = (ack_en && !o_sda_mode) ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    // Bus monitor: SCL rising-edge samples, START/STOP conditions, done pulses.
    int   cyc = 0;
    int   n_rise = 0, n_start = 0, n_stop = 0, n_done = 0, n_wide = 0;
    logic scl_prev = 1'b1, sda_prev = 1'b1, done_prev = 1'b0;
    logic bit_v  [0:511];
    logic mode_v [0:511];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        scl_prev  <= o_scl;
        sda_prev  <= io_sda;
        done_prev <= o_done_flag;
        if (!scl_prev && o_scl === 1'b1) begin
            bit_v[n_rise[8:0]]  <= io_sda;
            mode_v[n_rise[8:0]] <= o_sda_mode;
            n_rise <= n_rise + 1;
        end
        if (scl_prev && o_scl === 1'b1 && sda_prev === 1'b1 && io_sda === 1'b0) n_start <= n_start + 1;
        if (scl_prev && o_scl === 1'b1 && sda_prev === 1'b0 && io_sda === 1'b1) n_stop <= n_stop + 1;
        if (o_done_flag === 1'b1 && !done_prev) n_done <= n_done + 1;
        if (o_done_flag === 1'b1 && done_prev) n_wide <= n_wide + 1;
    end

    function automatic logic [7:0] get_byte(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = bit_v[9'(base + i)];
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_txn(input logic [6:0] d, input logic [7:0] a, input logic [7:0] w, output int sc);
        @(negedge clk);
        i_device_addr = d;
        i_data_addr   = a;
        i_write_data  = w;
        i_i2c_en      = 1'b1;
        sc = cyc + 1;
        @(negedge clk);
        i_i2c_en = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int dc);
        dc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (o_done_flag === 1'b1) begin
                dc = cyc;
                break;
            end
        end
    endtask

    task automatic check_frame(input int base, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        check("byte_dev",  32'(get_byte(base)), 32'(e0));
        check("ack1_mode", 32'(mode_v[9'(base + 8)]), 32'd0);
        check("byte_addr", 32'(get_byte(base + 9)), 32'(e1));
        check("ack2_mode", 32'(mode_v[9'(base + 17)]), 32'd0);
        check("byte_data", 32'(get_byte(base + 18)), 32'(e2));
        check("ack3_mode", 32'(mode_v[9'(base + 26)]), 32'd0);
        check("stop_mode", 32'(mode_v[9'(base + 27)]), 32'd1);
    endtask

    int sc, dc, dc2, r0, s0, p0, d0, w0;

    task automatic snap();
        r0 = n_rise; s0 = n_start; p0 = n_stop; d0 = n_done; w0 = n_wide;
    endtask

    initial begin
        rst_n = 1'b1; ack_en = 1'b1; i_i2c_en = 1'b0;
        i_device_addr = '0; i_data_addr = '0; i_write_data = '0;
        #2 rst_n = 1'b0;

        // Reset values
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_scl",  32'(o_scl), 32'd1);
        check("rst_mode", 32'(o_sda_mode), 32'd1);
        check("rst_sda",  32'(io_sda), 32'd1);
        check("rst_done", 32'(o_done_flag), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Normal ACKed write: 116 quarters -> done 465 clk after the sampling edge
        #1 snap();
        start_txn(7'h50, 8'hA5, 8'h3C, sc);
        wait_done(600, dc);
        check("norm_done_seen", 32'(dc >= 0), 32'd1);
        check("norm_latency", 32'(dc - sc >= 464 && dc - sc <= 466), 32'd1);
        repeat (4) @(negedge clk);
        #1;
        check("norm_rises", 32'(n_rise - r0), 32'd28);
        check("norm_starts", 32'(n_start - s0), 32'd1);
        check("norm_stops", 32'(n_stop - p0), 32'd1);
        check("norm_dones", 32'(n_done - d0), 32'd1);
        check("norm_width", 32'(n_wide - w0), 32'd0);
        check_frame(r0, 8'hA0, 8'hA5, 8'h3C);

        // NACK on address: 4 + 9*4 + 4 = 44 quarters -> 177 clk
        ack_en = 1'b0;
        #1 snap();
        start_txn(7'h50, 8'hA5, 8'h3C, sc);
        wait_done(600, dc);
        check("nack_latency", 32'(dc - sc >= 176 && dc - sc <= 178), 32'd1);
        repeat (20) @(negedge clk);
        #1;
        check("nack_rises", 32'(n_rise - r0), 32'd10);
        check("nack_byte", 32'(get_byte(r0)), 32'hA0);
        check("nack_ack_mode", 32'(mode_v[9'(r0 + 8)]), 32'd0);
        check("nack_stops", 32'(n_stop - p0), 32'd1);
        check("nack_dones", 32'(n_done - d0), 32'd1);
        ack_en = 1'b1;

        // Inputs changed mid-transfer are ignored
        #1 snap();
        start_txn(7'h50, 8'hA5, 8'h3C, sc);
        repeat (100) @(negedge clk);
        i_write_data = 8'hFF;
        i_device_addr = 7'h7F;
        wait_done(600, dc);
        check("stab_done_seen", 32'(dc >= 0), 32'd1);
        repeat (4) @(negedge clk);
        #1;
        check_frame(r0, 8'hA0, 8'hA5, 8'h3C);

        // Back-to-back with i_i2c_en held high
        #1 snap();
        @(negedge clk);
        i_device_addr = 7'h11; i_data_addr = 8'h81; i_write_data = 8'h7E;
        i_i2c_en = 1'b1;
        wait_done(600, dc);
        wait_done(600, dc2);
        i_i2c_en = 1'b0;
        check("b2b_done1_seen", 32'(dc >= 0), 32'd1);
        check("b2b_gap", 32'(dc2 - dc >= 465 && dc2 - dc <= 467), 32'd1);
        repeat (50) @(negedge clk);
        #1;
        check("b2b_dones", 32'(n_done - d0), 32'd2);
        check("b2b_starts", 32'(n_start - s0), 32'd2);
        check("b2b_rises", 32'(n_rise - r0), 32'd56);
        check("b2b_idle_scl", 32'(o_scl), 32'd1);
        check_frame(r0, 8'h22, 8'h81, 8'h7E);
        check_frame(r0 + 28, 8'h22, 8'h81, 8'h7E);

        // Reset during DATA_ADDR bit 3 (SCL low in that slot's q0)
        start_txn(7'h50, 8'hA5, 8'h3C, sc);
        repeat (210) @(negedge clk);
        check("mid_scl_low", 32'(o_scl), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_scl", 32'(o_scl), 32'd1);
        check("mid_rst_mode", 32'(o_sda_mode), 32'd1);
        check("mid_rst_sda", 32'(io_sda), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1 snap();
        start_txn(7'h2B, 8'h0F, 8'hC3, sc);
        wait_done(600, dc);
        check("post_latency", 32'(dc - sc >= 464 && dc - sc <= 466), 32'd1);
        repeat (4) @(negedge clk);
        #1;
        check("post_rises", 32'(n_rise - r0), 32'd28);
        check_frame(r0, 8'h56, 8'h0F, 8'hC3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
